// File: rtl/serial_subtractor_v.sv
// Bit-serial unsigned subtractor (LSB first): one full-subtractor cell plus a
// borrow flop, wrapped in a start/busy/done handshake toward the controller.
module serial_subtractor_v #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_diff_q, res_diff_d;
    logic             res_borrow_q, res_borrow_d;
    logic             res_zero_q, res_zero_d;

    // Full-subtractor cell and the diff register as it looks after this bit
    logic             a_k, b_k;
    logic             d_k;
    logic             bw_next;
    logic [WIDTH-1:0] diff_shifted;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves a variable
        // unassigned and no latch is inferred.
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        diff_d       = diff_q;
        bw_d         = bw_q;
        cnt_d        = cnt_q;
        res_diff_d   = res_diff_q;
        res_borrow_d = res_borrow_q;
        res_zero_d   = res_zero_q;

        a_k          = a_q[0];
        b_k          = b_q[0];
        d_k          = a_k ^ b_k ^ bw_q;
        bw_next      = (~a_k & b_k) | (~(a_k ^ b_k) & bw_q);
        diff_shifted = {d_k, diff_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    diff_d  = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = diff_shifted;
                bw_d   = bw_next;
                cnt_d  = cnt_q + CW'(1);
                // Results take the final bit straight from the cell, not the register
                if (cnt_q == LAST_BIT) begin
                    state_d      = S_DONE;
                    res_diff_d   = diff_shifted;
                    res_borrow_d = bw_next;
                    res_zero_d   = (diff_shifted == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            bw_q         <= 1'b0;
            cnt_q        <= '0;
            res_diff_q   <= '0;
            res_borrow_q <= 1'b0;
            res_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            diff_q       <= diff_d;
            bw_q         <= bw_d;
            cnt_q        <= cnt_d;
            res_diff_q   <= res_diff_d;
            res_borrow_q <= res_borrow_d;
            res_zero_q   <= res_zero_d;
        end
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = (state_q == S_DONE);
    assign o_diff   = res_diff_q;
    assign o_borrow = res_borrow_q;
    assign o_zero   = res_zero_q;

endmodule

// File: tb/tb_serial_subtractor_v.sv
// Bench for serial_subtractor_v: an arithmetic reference model checked every
// cycle on WIDTH=8 and WIDTH=4 instances, plus hand-computed directed vectors.
module tb_serial_subtractor_v;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8, zero8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, borrow4, zero4;
    logic [3:0] diff4;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_v #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8),
        .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_borrow(borrow8), .o_zero(zero8)
    );

    serial_subtractor_v #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_a(a4), .i_b(b4),
        .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_borrow(borrow4), .o_zero(zero4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since acceptance; results appear WIDTH edges later
    int         m8_cnt = -1;
    logic [7:0] m8_a = '0, m8_b = '0, m8_diff = '0;
    logic       m8_borrow = 1'b0, m8_zero = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_cnt = -1; m8_diff = '0; m8_borrow = 1'b0; m8_zero = 1'b0;
        end else if (m8_cnt < 0) begin
            if (start8) begin m8_a = a8; m8_b = b8; m8_cnt = 0; end
        end else begin
            m8_cnt++;
            if (m8_cnt == 8) begin
                m8_diff = m8_a - m8_b; m8_borrow = (m8_a < m8_b); m8_zero = (m8_diff == 0);
            end else if (m8_cnt == 9) m8_cnt = -1;
        end
    end

    int         m4_cnt = -1;
    logic [3:0] m4_a = '0, m4_b = '0, m4_diff = '0;
    logic       m4_borrow = 1'b0, m4_zero = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_cnt = -1; m4_diff = '0; m4_borrow = 1'b0; m4_zero = 1'b0;
        end else if (m4_cnt < 0) begin
            if (start4) begin m4_a = a4; m4_b = b4; m4_cnt = 0; end
        end else begin
            m4_cnt++;
            if (m4_cnt == 4) begin
                m4_diff = m4_a - m4_b; m4_borrow = (m4_a < m4_b); m4_zero = (m4_diff == 0);
            end else if (m4_cnt == 5) m4_cnt = -1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("w8_busy",   busy8,   (m8_cnt >= 0));
            check("w8_done",   done8,   (m8_cnt == 8));
            check("w8_diff",   diff8,   m8_diff);
            check("w8_borrow", borrow8, m8_borrow);
            check("w8_zero",   zero8,   m8_zero);
            check("w4_busy",   busy4,   (m4_cnt >= 0));
            check("w4_done",   done4,   (m4_cnt == 4));
            check("w4_diff",   diff4,   m4_diff);
            check("w4_borrow", borrow4, m4_borrow);
            check("w4_zero",   zero4,   m4_zero);
        end
    end

    // Pulse start for one cycle, then expect o_done on the 9th following negedge
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic ez);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b;
        n = 1;
        while (!done8 && n < 20) begin @(negedge clk); n++; end
        check("lat8", n, 9);
        check("diff8", diff8, ed);
        check("borrow8", borrow8, eb);
        check("zero8", zero8, ez);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input int gap);
        int n;
        logic [3:0] ed;
        @(negedge clk);
        for (int g = 0; g < gap; g++) @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 12) begin @(negedge clk); n++; end
        ed = a - b;
        check("lat4", n, 5);
        check("diff4", diff4, ed);
        check("borrow4", borrow4, (a < b));
        check("zero4", zero4, (ed == 4'h0));
    endtask

    initial begin
        int n_done, last, cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        check("rst_borrow", borrow8, 0);
        check("rst_zero", zero8, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        run8(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
        run8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        run8(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

        // Start request during RUN must be dropped
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); a8 = 8'h99; b8 = 8'h11; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        n_done = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done8) begin n_done++; check("t3_diff", diff8, 8'h0F); end
        end
        check("t3_ndone", n_done, 1);

        // Start held high: back-to-back ops, operands changing every cycle
        @(negedge clk);
        a8 = 8'h37; b8 = 8'h15; start8 = 1'b1;
        n_done = 0; last = 0;
        for (cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            if (done8) begin
                if (n_done == 0) check("t4_first", diff8, 8'h22);
                else check("t4_spacing", cyc - last, 10);
                n_done++; last = cyc;
            end
            a8 = a8 + 8'd3; b8 = b8 + 8'd1;
        end
        start8 = 1'b0;
        check("t4_ndone", n_done, 3);
        repeat (12) @(negedge clk);

        // Reset mid-RUN: outputs cleared immediately, no done afterwards
        run8(8'h20, 8'h03, 8'h1D, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'h44; b8 = 8'h22; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", busy8, 0);
        check("t5_done", done8, 0);
        check("t5_diff", diff8, 0);
        check("t5_borrow", borrow8, 0);
        check("t5_zero", zero8, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (done8) n_done++; end
        check("t5_nodone", n_done, 0);
        run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

        // WIDTH=4 exhaustive with random idle gaps
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            run4(v[7:4], v[3:0], int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
